// File: rtl/branch_resolve_unit_if.sv
// Fetch/EX-side signal bundle for the branch resolve unit.
// master: pipeline side, slave: the resolve unit.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            ex_is_branch;
  logic            ex_is_jump;
  logic            ex_stall;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_cmp_res;
  logic            ex_pred_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [31:0]     br_cnt;
  logic [31:0]     mispred_cnt;

  modport master (
    output if_pc,
    output ex_valid,
    output ex_is_branch,
    output ex_is_jump,
    output ex_stall,
    output ex_pc,
    output ex_target,
    output ex_cmp_res,
    output ex_pred_taken,
    input  if_pred_taken,
    input  redirect_valid,
    input  redirect_pc,
    input  flush,
    input  br_cnt,
    input  mispred_cnt
  );

  modport slave (
    input  if_pc,
    input  ex_valid,
    input  ex_is_branch,
    input  ex_is_jump,
    input  ex_stall,
    input  ex_pc,
    input  ex_target,
    input  ex_cmp_res,
    input  ex_pred_taken,
    output if_pred_taken,
    output redirect_valid,
    output redirect_pc,
    output flush,
    output br_cnt,
    output mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// BHT-based branch predictor with EX-stage resolution
// and a registered one-cycle redirect/flush pulse.
module branch_resolve_unit #(
  parameter int IDX_W = 4,
  parameter int XLEN  = 32
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);
  localparam int N = 1 << IDX_W;

  logic [1:0]      bht_q [N];
  logic [1:0]      bht_d [N];
  logic            rv_q, rv_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [31:0]     brc_q, brc_d;
  logic [31:0]     mpc_q, mpc_d;

  logic             is_br;
  logic             res;
  logic             act;
  logic             mis;
  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] if_idx;
  logic [XLEN-1:0]  seq_pc;

  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign seq_pc = bus.ex_pc + XLEN'(4);

  // A jump flag dominates the branch flag.
  always_comb begin
    is_br = bus.ex_is_branch & ~bus.ex_is_jump;
    res   = bus.ex_valid & ~bus.ex_stall & ~rv_q
          & (bus.ex_is_branch | bus.ex_is_jump);
    act   = bus.ex_is_jump | bus.ex_cmp_res;
    mis   = res & (act != bus.ex_pred_taken);
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (res && is_br) begin
      if (act && bht_q[ex_idx] != 2'b11) begin
        bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
      end else if (!act && bht_q[ex_idx] != 2'b00) begin
        bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
      end
    end
  end

  always_comb begin
    rv_d  = mis;
    rpc_d = rpc_q;
    brc_d = brc_q;
    mpc_d = mpc_q;
    if (mis) begin
      rpc_d = act ? bus.ex_target : seq_pc;
      mpc_d = mpc_q + 32'd1;
    end
    if (res && is_br) begin
      brc_d = brc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        bht_q[i] <= 2'b01;
      end
      rv_q  <= 1'b0;
      rpc_q <= '0;
      brc_q <= '0;
      mpc_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        bht_q[i] <= bht_d[i];
      end
      rv_q  <= rv_d;
      rpc_q <= rpc_d;
      brc_q <= brc_d;
      mpc_q <= mpc_d;
    end
  end

  // No bypass: lookup sees the pre-update counter.
  assign bus.if_pred_taken  = bht_q[if_idx][1];
  assign bus.redirect_valid = rv_q;
  assign bus.flush          = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.br_cnt         = brc_q;
  assign bus.mispred_cnt    = mpc_q;
endmodule
